pid_loop_sequencer: RTL and testbench
=====================================

PID_LOOP_SEQUENCER -- requirements
Module: pid_loop_sequencer

Interface
REQ-001 SENSOR_ADDR, 16'hDEAD, Avalon-MM address of temperature sensor register.
REQ-002 PWM_ADDR, 16'hDEAD, Avalon-MM address of PWM duty register.
REQ-003 PERIOD, 1000, sample period in clk cycles; legal range >= 16.
REQ-004 RD_TIMEOUT, 64, maximum cycles from read acceptance to temp_readdatavalid.
REQ-005 PWM_MAX, 4095, upper clamp of written duty; lower clamp is 0.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 enable  in  1  loop run enable; low stops tick generation.
REQ-009 temp_address  out  16  sensor read address.
REQ-010 temp_read  out  1  Avalon read request.
REQ-011 temp_readdata  in  32  signed temperature.
REQ-012 temp_readdatavalid  in  1  read data strobe.
REQ-013 temp_waitrequest  in  1  sensor slave stall.
REQ-014 calc_start  out  1  one-cycle pulse starting the PID core.
REQ-015 calc_meas  out  32  signed measurement given to the PID core, stable from calc_start until calc_done.
REQ-016 calc_done  in  1  PID core result strobe.
REQ-017 calc_out  in  32  signed PID core result, valid with calc_done.
REQ-018 pwm_address  out  16  PWM write address.
REQ-019 pwm_write  out  1  Avalon write request.
REQ-020 pwm_writedata  out  32  clamped duty value.
REQ-021 pwm_waitrequest  in  1  PWM slave stall.
REQ-022 busy  out  1  high in any state other than IDLE.
REQ-023 overrun  out  1  sticky; a tick arrived while busy.
REQ-024 timeout_err  out  1  sticky; sensor read timed out.
REQ-025 sample_cnt  out  16  completed PWM writes, wraps 16'hFFFF -> 0.

Function
REQ-026 Period counter SHALL count 0..PERIOD-1 while enable=1 and emit tick at PERIOD-1; enable=0 SHALL hold the counter at 0.
REQ-027 FSM states SHALL be IDLE, RD_REQ, RD_WAIT, CALC, WR_REQ.
REQ-028 IDLE + tick -> RD_REQ; RD_REQ SHALL assert temp_read with temp_address=SENSOR_ADDR, held stable until the cycle temp_read && !temp_waitrequest, then -> RD_WAIT.
REQ-029 RD_WAIT + temp_readdatavalid SHALL latch temp_readdata into calc_meas, pulse calc_start on the next cycle, and go to CALC.
REQ-030 RD_WAIT without temp_readdatavalid for RD_TIMEOUT cycles SHALL set timeout_err and return to IDLE with no PWM write.
REQ-031 CALC + calc_done SHALL latch clamp(calc_out): <0 -> 0, >PWM_MAX -> PWM_MAX, else unchanged; then -> WR_REQ.
REQ-032 WR_REQ SHALL assert pwm_write with pwm_address=PWM_ADDR and the latched duty, held stable until pwm_write && !pwm_waitrequest, then increment sample_cnt and -> IDLE.
REQ-033 Tick while not IDLE SHALL set overrun and be dropped, never queued.
REQ-034 temp_readdatavalid outside RD_WAIT and calc_done outside CALC SHALL be ignored.
REQ-035 enable falling mid-cycle SHALL NOT abort the current transaction; the FSM SHALL finish to IDLE.
REQ-036 temp_read and pwm_write SHALL never be asserted in the same cycle.

Reset
REQ-037 Reset SHALL force IDLE, period counter 0, temp_read=0, pwm_write=0, calc_start=0, calc_meas=0, pwm_writedata=0, addresses=0, busy=0, overrun=0, timeout_err=0, sample_cnt=0.
REQ-038 Reset asserted mid-transaction SHALL drop request signals on the next edge; the interrupted transaction SHALL NOT be resumed.

Structure
REQ-039 The FSM state enum and the default PWM_MAX constant SHALL live in shared package pid_pkg.
REQ-040 The period counter SHALL be sub-module pid_tick_gen (PERIOD parameter; enable in; tick out).

Verification
REQ-041 PERIOD=100, waitrequest high 6 cycles, readdatavalid 5 cycles after accept, temp=30, calc_out=1200 -> exactly one PWM write of 1200 per 100 cycles; sample_cnt increments by 1 each time.
REQ-042 calc_out=-20 -> pwm_writedata=0; calc_out=5000 -> pwm_writedata=4095.
REQ-043 readdatavalid withheld, RD_TIMEOUT=64 -> timeout_err=1 at cycle 64 after accept, no pwm_write, next tick restarts a read.
REQ-044 calc_done delayed beyond PERIOD -> overrun=1, the delayed tick gets no extra read, the result is still written once.
REQ-045 Reset pulsed during WR_REQ with pwm_waitrequest high -> pwm_write=0 on the next edge, sample_cnt=0, IDLE.
REQ-046 sample_cnt preloaded via 65535 completed loops -> the next write wraps it to 0, with temp_read and pwm_write never high together.

Source files
------------

// File: rtl/pid_pkg.sv
// pid_pkg: shared FSM state type, default duty clamp and clamp helper for the PID loop sequencer.
package pid_pkg;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, CALC, WR_REQ} state_t;
  localparam int PWM_MAX_DEF = 4095;
  function automatic logic [31:0] clamp_duty(input logic signed [31:0] v, input int max);
    return v < 0 ? 32'd0 : v > max ? 32'(max) : v;
  endfunction
endpackage

// File: rtl/pid_tick_gen.sv
// pid_tick_gen: free-running sample period counter; tick on the last count while enabled.
module pid_tick_gen #(
  parameter int PERIOD = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(PERIOD);
  logic [W-1:0] cnt;
  assign tick = enable && cnt == W'(PERIOD - 1);
  always_ff @(posedge clk) begin
    if (reset || !enable) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/pid_loop_sequencer.sv
// pid_loop_sequencer: per tick reads the sensor, runs the PID core, writes the clamped duty to the PWM.
module pid_loop_sequencer
  import pid_pkg::*;
#(
  parameter logic [15:0] SENSOR_ADDR = 16'hDEAD,
  parameter logic [15:0] PWM_ADDR    = 16'hDEAD,
  parameter int          PERIOD      = 1000,
  parameter int          RD_TIMEOUT  = 64,
  parameter int          PWM_MAX     = PWM_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] temp_address,
  output logic        temp_read,
  input  logic [31:0] temp_readdata,
  input  logic        temp_readdatavalid,
  input  logic        temp_waitrequest,
  output logic        calc_start,
  output logic [31:0] calc_meas,
  input  logic        calc_done,
  input  logic [31:0] calc_out,
  output logic [15:0] pwm_address,
  output logic        pwm_write,
  output logic [31:0] pwm_writedata,
  input  logic        pwm_waitrequest,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err,
  output logic [15:0] sample_cnt
);
  localparam int TW = $clog2(RD_TIMEOUT);
  state_t state;
  logic tick;
  logic [TW-1:0] tmo;
  pid_tick_gen #(.PERIOD(PERIOD)) u_tick (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      temp_read     <= 1'b0;
      temp_address  <= '0;
      calc_start    <= 1'b0;
      calc_meas     <= '0;
      pwm_write     <= 1'b0;
      pwm_address   <= '0;
      pwm_writedata <= '0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
      sample_cnt    <= '0;
      tmo           <= '0;
    end else begin
      calc_start <= 1'b0;
      // a tick that finds the loop busy is recorded and dropped, never queued
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          state        <= RD_REQ;
          temp_read    <= 1'b1;
          temp_address <= SENSOR_ADDR;
          busy         <= 1'b1;
        end
        RD_REQ: if (!temp_waitrequest) begin
          state        <= RD_WAIT;
          temp_read    <= 1'b0;
          temp_address <= '0;
          tmo          <= '0;
        end
        RD_WAIT: if (temp_readdatavalid) begin
          state      <= CALC;
          calc_meas  <= temp_readdata;
          calc_start <= 1'b1;
        end else if (tmo == TW'(RD_TIMEOUT - 1)) begin
          state       <= IDLE;
          timeout_err <= 1'b1;
          busy        <= 1'b0;
        end else begin
          tmo <= tmo + 1'b1;
        end
        CALC: if (calc_done) begin
          state         <= WR_REQ;
          pwm_writedata <= clamp_duty(calc_out, PWM_MAX);
          pwm_write     <= 1'b1;
          pwm_address   <= PWM_ADDR;
        end
        WR_REQ: if (!pwm_waitrequest) begin
          state       <= IDLE;
          pwm_write   <= 1'b0;
          pwm_address <= '0;
          sample_cnt  <= sample_cnt + 1'b1;
          busy        <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pid_loop_sequencer.sv
// tb_pid_loop_sequencer: reactive sensor/PID/PWM models with a write-data scoreboard.
module tb_pid_loop_sequencer;
  localparam int PERIOD = 100;
  localparam int RD_TIMEOUT = 64;
  logic clk = 0, reset, enable;
  logic [15:0] temp_address, pwm_address, sample_cnt;
  logic temp_read, temp_readdatavalid, temp_waitrequest;
  logic [31:0] temp_readdata, calc_meas, calc_out, pwm_writedata;
  logic calc_start, calc_done, pwm_write, pwm_waitrequest, busy, overrun, timeout_err;
  int checks = 0, errors = 0, reads = 0, writes = 0, starts = 0, cyc = 0;
  int rd_stall = 6, rd_lat = 5, calc_lat = 3, wr_stall = 2;
  bit withhold = 0;
  logic [31:0] temp_val = 30, calc_val = 1200;
  logic [31:0] exp_q[$];
  int wr_cyc[$];

  pid_loop_sequencer #(
    .SENSOR_ADDR(16'h1234), .PWM_ADDR(16'h5678), .PERIOD(PERIOD),
    .RD_TIMEOUT(RD_TIMEOUT), .PWM_MAX(4095)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .temp_address(temp_address), .temp_read(temp_read), .temp_readdata(temp_readdata),
    .temp_readdatavalid(temp_readdatavalid), .temp_waitrequest(temp_waitrequest),
    .calc_start(calc_start), .calc_meas(calc_meas), .calc_done(calc_done), .calc_out(calc_out),
    .pwm_address(pwm_address), .pwm_write(pwm_write), .pwm_writedata(pwm_writedata),
    .pwm_waitrequest(pwm_waitrequest), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && writes < n; i++) @(negedge clk);
    check("write_count", writes, n);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    check("idle", busy, 0);
  endtask

  // sensor slave: stall, then return data or withhold it
  initial begin
    temp_waitrequest = 1; temp_readdatavalid = 0; temp_readdata = 0;
    forever begin
      @(negedge clk);
      if (temp_read && !reset) begin
        reads++;
        check("rd_addr", temp_address, 16'h1234);
        repeat (rd_stall - 1) @(negedge clk);
        temp_waitrequest = 0;
        @(negedge clk);
        temp_waitrequest = 1;
        check("rd_drop", temp_read, 0);
        if (withhold) begin
          repeat (RD_TIMEOUT - 1) @(negedge clk);
          check("tmo_early", timeout_err, 0);
          @(negedge clk);
          check("tmo_at_64", timeout_err, 1);
        end else begin
          repeat (rd_lat - 1) @(negedge clk);
          temp_readdata = temp_val; temp_readdatavalid = 1;
          @(negedge clk);
          temp_readdatavalid = 0;
        end
      end
    end
  end

  // PID core model
  initial begin
    calc_done = 0; calc_out = 0;
    forever begin
      @(negedge clk);
      if (calc_start) begin
        starts++;
        check("calc_meas", calc_meas, temp_val);
        @(negedge clk);
        check("start_pulse", calc_start, 0);
        repeat (calc_lat - 2) @(negedge clk);
        check("meas_hold", calc_meas, temp_val);
        calc_out = calc_val; calc_done = 1;
        @(negedge clk);
        calc_done = 0;
      end
    end
  end

  // PWM slave: stall wr_stall cycles, give up if the request vanishes
  initial begin
    pwm_waitrequest = 1;
    forever begin
      @(negedge clk);
      if (pwm_write) begin
        for (int i = 1; i < wr_stall && pwm_write; i++) @(negedge clk);
        if (pwm_write) begin
          pwm_waitrequest = 0;
          @(negedge clk);
          pwm_waitrequest = 1;
        end
      end
    end
  end

  // monitor: pops the scoreboard on every accepted PWM write
  initial forever begin
    @(negedge clk);
    #2;
    if (temp_read || pwm_write) check("rd_wr_excl", temp_read && pwm_write, 0);
    if (pwm_write && !pwm_waitrequest && !reset) begin
      writes++;
      wr_cyc.push_back(cyc);
      check("wr_addr", pwm_address, 16'h5678);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected: got data %0d, expected no write", pwm_writedata);
      end else check("wr_data", pwm_writedata, exp_q.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    reset = 1; enable = 0;
    repeat (3) @(negedge clk);
    check("rst_temp_read", temp_read, 0);
    check("rst_pwm_write", pwm_write, 0);
    check("rst_calc_start", calc_start, 0);
    check("rst_calc_meas", calc_meas, 0);
    check("rst_writedata", pwm_writedata, 0);
    check("rst_temp_addr", temp_address, 0);
    check("rst_pwm_addr", pwm_address, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_cnt", sample_cnt, 0);
    reset = 0;
    // steady loop, one write per period
    repeat (3) exp_q.push_back(1200);
    enable = 1;
    wait_writes(3, 400);
    check("period", wr_cyc.size() >= 3 ? wr_cyc[2] - wr_cyc[1] : 0, PERIOD);
    check("cnt3", sample_cnt, 3);
    check("reads3", reads, 3);
    check("starts3", starts, 3);
    // enable drops mid-transaction: loop still completes
    for (int i = 0; i < 200 && !temp_read; i++) @(negedge clk);
    exp_q.push_back(1200);
    enable = 0;
    wait_writes(4, 100);
    repeat (300) @(negedge clk);
    check("no_more_writes", writes, 4);
    check("cnt4", sample_cnt, 4);
    check("no_overrun", overrun, 0);
    // clamp boundaries
    calc_val = 32'hFFFF_FFEC; exp_q.push_back(0);
    enable = 1;
    wait_writes(5, 150);
    calc_val = 5000; exp_q.push_back(4095);
    wait_writes(6, 150);
    calc_val = 4096; exp_q.push_back(4095);
    wait_writes(7, 150);
    calc_val = 4095; exp_q.push_back(4095);
    wait_writes(8, 150);
    calc_val = 0; exp_q.push_back(0);
    wait_writes(9, 150);
    enable = 0;
    wait_idle(100);
    // stray strobes in IDLE are ignored
    temp_readdatavalid = 1; calc_done = 1;
    @(negedge clk);
    temp_readdatavalid = 0; calc_done = 0;
    @(negedge clk);
    check("stray_busy", busy, 0);
    check("stray_start", calc_start, 0);
    // read timeout, then next tick reads again
    r0 = reads; withhold = 1; enable = 1;
    for (int i = 0; i < 200 && !timeout_err; i++) @(negedge clk);
    check("tmo_seen", timeout_err, 1);
    withhold = 0; calc_val = 1200; exp_q.push_back(1200);
    wait_writes(10, 150);
    enable = 0;
    check("tmo_reread", reads, r0 + 2);
    check("tmo_sticky", timeout_err, 1);
    wait_idle(100);
    // calc slower than a period: overrun, dropped tick, single write
    r0 = reads; calc_lat = 150; exp_q.push_back(1200);
    enable = 1;
    wait_writes(11, 400);
    enable = 0;
    repeat (300) @(negedge clk);
    check("overrun", overrun, 1);
    check("ovr_reads", reads, r0 + 1);
    check("ovr_writes", writes, 11);
    calc_lat = 3;
    // reset while the PWM write stalls
    wr_stall = 1000; exp_q.push_back(1200);
    enable = 1;
    for (int i = 0; i < 300 && !pwm_write; i++) @(negedge clk);
    check("wr_pending", pwm_write, 1);
    reset = 1;
    @(negedge clk);
    check("rst_mid_write", pwm_write, 0);
    check("rst_mid_cnt", sample_cnt, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_overrun", overrun, 0);
    reset = 0; enable = 0; wr_stall = 2;
    void'(exp_q.pop_back());
    repeat (300) @(negedge clk);
    check("no_resume", writes, 11);
    check("no_resume_write", pwm_write, 0);
    // counter wrap from 16'hFFFF
    force dut.sample_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.sample_cnt;
    @(negedge clk);
    if (sample_cnt === 16'hFFFF) begin
      exp_q.push_back(1200);
      enable = 1;
      wait_writes(12, 150);
      enable = 0;
      check("cnt_wrap", sample_cnt, 0);
      wait_idle(100);
    end
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
